network_sink: RTL

//  Output end of the dispatch protocol: encodes per-cycle network fire vectors into

---
 rtl/network_sink_pkg.sv | 32 +++
 rtl/network_sink_lowest_set_index.sv | 24 ++
 rtl/network_sink.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/network_sink_pkg.sv
// Shared types and widths for the network sink: opcode encoding, packet layout
// and the sink FSM state type.
package network_sink_pkg;

  localparam int NET_NUM_OUT = 4;
  localparam int OPC_WIDTH   = 2;
  localparam int SNK_WIDTH   = 20;
  localparam int PAY_WIDTH   = SNK_WIDTH - OPC_WIDTH;
  localparam int IDX_WIDTH   = (NET_NUM_OUT > 1) ? $clog2(NET_NUM_OUT) : 1;

  typedef enum logic [OPC_WIDTH-1:0] {
    OPC_NOP = 2'd0,
    OPC_RUN = 2'd1,
    OPC_SPK = 2'd2
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    EMIT_RUN,
    EMIT_SPK
  } snk_state_t;

  // Opcode in the MSBs, a payload of 'width' bits MSB-justified below it, zero pad.
  function automatic logic [SNK_WIDTH-1:0] make_pkt(input opcode_t opc,
                                                    input logic [PAY_WIDTH-1:0] payload,
                                                    input int unsigned width);
    logic [PAY_WIDTH-1:0] shifted;
    shifted = payload << (PAY_WIDTH - width);
    return {opc, shifted};
  endfunction

endpackage

// File: rtl/network_sink_lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of vec.
module lowest_set_index #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [WIDTH-1:0]     vec,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  always_comb begin
    // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
    found = 1'b0;
    idx   = '0;
    // Scanning downward lets the lowest set bit overwrite any higher one.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found = 1'b1;
        idx   = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/network_sink.sv
// Encodes per-cycle network fire vectors into host packets: empty cycles are
// run-length compressed into RUN packets, every fired output becomes one SPK packet.
module network_sink
  import network_sink_pkg::*;
#(
  parameter int RUN_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   arstn,
  input  logic                   net_valid,
  output logic                   net_ready,
  input  logic [NET_NUM_OUT-1:0] net_out,
  input  logic                   flush,
  output logic                   snk_valid,
  input  logic                   snk_ready,
  output logic [SNK_WIDTH-1:0]   snk
);

  if (RUN_WIDTH > PAY_WIDTH || IDX_WIDTH > PAY_WIDTH) begin : g_width_check
    $error("network_sink: payload does not fit in SNK_WIDTH-OPC_WIDTH");
  end

  localparam logic [RUN_WIDTH-1:0] CMAX = '1;

  snk_state_t             state, state_d;
  logic [RUN_WIDTH-1:0]   pend, pend_d;
  logic [NET_NUM_OUT-1:0] mask, mask_d;
  logic                   flush_req, flush_req_d;
  logic                   snk_valid_d;
  logic [SNK_WIDTH-1:0]   snk_d;
  logic                   capture;

  logic [NET_NUM_OUT-1:0] enc_in;
  logic                   enc_found;
  logic [IDX_WIDTH-1:0]   enc_idx;

  function automatic logic [SNK_WIDTH-1:0] run_pkt(input logic [RUN_WIDTH-1:0] n);
    return make_pkt(OPC_RUN, PAY_WIDTH'(n), RUN_WIDTH);
  endfunction

  function automatic logic [SNK_WIDTH-1:0] spk_pkt(input logic [IDX_WIDTH-1:0] i);
    return make_pkt(OPC_SPK, PAY_WIDTH'(i), IDX_WIDTH);
  endfunction

  // The encoder always looks at the mask the next SPK packet will be taken from.
  always_comb begin
    unique case (state)
      IDLE:     enc_in = net_out;
      EMIT_RUN: enc_in = mask;
      default:  enc_in = mask & (mask - NET_NUM_OUT'(1));
    endcase
  end

  lowest_set_index #(
    .WIDTH    (NET_NUM_OUT),
    .IDX_WIDTH(IDX_WIDTH)
  ) u_lsi (
    .vec  (enc_in),
    .found(enc_found),
    .idx  (enc_idx)
  );

  // A latched flush is serviced before any new capture, so it also blocks net_ready.
  assign net_ready = (state == IDLE) && (pend != CMAX) && !flush_req;
  assign capture   = net_valid && net_ready;

  always_comb begin
    state_d     = state;
    pend_d      = pend;
    mask_d      = mask;
    flush_req_d = flush_req;
    snk_valid_d = snk_valid;
    snk_d       = snk;
    unique case (state)
      IDLE: begin
        if (capture) begin
          if (flush) flush_req_d = 1'b1;
          if (enc_found) begin
            mask_d      = net_out;
            snk_valid_d = 1'b1;
            if (pend != '0) begin
              state_d = EMIT_RUN;
              snk_d   = run_pkt(pend);
            end else begin
              state_d = EMIT_SPK;
              snk_d   = spk_pkt(enc_idx);
            end
          end else begin
            pend_d = pend + RUN_WIDTH'(1);
            if (pend_d == CMAX) begin
              state_d     = EMIT_RUN;
              snk_valid_d = 1'b1;
              snk_d       = run_pkt(pend_d);
            end
          end
        end else if (flush || flush_req) begin
          flush_req_d = 1'b0;
          if (pend != '0) begin
            state_d     = EMIT_RUN;
            snk_valid_d = 1'b1;
            snk_d       = run_pkt(pend);
          end
        end
      end
      EMIT_RUN: begin
        if (flush) flush_req_d = 1'b1;
        if (snk_ready) begin
          pend_d = '0;
          if (enc_found) begin
            state_d = EMIT_SPK;
            snk_d   = spk_pkt(enc_idx);
          end else begin
            state_d     = IDLE;
            snk_valid_d = 1'b0;
            snk_d       = '0;
          end
        end
      end
      EMIT_SPK: begin
        if (flush) flush_req_d = 1'b1;
        if (snk_ready) begin
          mask_d = enc_in;
          if (enc_found) begin
            snk_d = spk_pkt(enc_idx);
          end else begin
            // Last spike sent: the cycle boundary it belongs to opens the next run.
            state_d     = IDLE;
            pend_d      = RUN_WIDTH'(1);
            snk_valid_d = 1'b0;
            snk_d       = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state     <= IDLE;
      pend      <= '0;
      mask      <= '0;
      flush_req <= 1'b0;
      snk_valid <= 1'b0;
      snk       <= '0;
    end else begin
      state     <= state_d;
      pend      <= pend_d;
      mask      <= mask_d;
      flush_req <= flush_req_d;
      snk_valid <= snk_valid_d;
      snk       <= snk_d;
    end
  end

endmodule
